// File: rtl/bnn_pkg.sv
// Shared constants and types for the BNN MLP front end (feature flattener).
package bnn_pkg;

  localparam int unsigned NUM_PIXELS  = 36;
  localparam int unsigned CHANNELS    = 8;
  localparam int unsigned FLAT_WIDTH  = NUM_PIXELS * CHANNELS;
  localparam int unsigned COUNT_WIDTH = $clog2(NUM_PIXELS);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/mlp_feature_flattener_if.sv
// Pixel-stream input and flat-vector output handshakes of the feature flattener.
interface mlp_feature_flattener_if;
  import bnn_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [CHANNELS-1:0]   in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [FLAT_WIDTH-1:0] out_vec;
  logic                  frame_err;

  // master: feature producer plus MLP consumer; slave: the flattener
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_vec, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_vec, frame_err
  );
endinterface

// File: rtl/mlp_flatten_bank.sv
// One flat feature-vector register, written one pixel slot at a time.
module mlp_flatten_bank
  import bnn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [COUNT_WIDTH-1:0] wr_idx,
  input  logic [CHANNELS-1:0]    wr_data,
  output logic [FLAT_WIDTH-1:0]  q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < int'(NUM_PIXELS); i++) begin
        if (wr_idx == COUNT_WIDTH'(i)) begin
          q[i*CHANNELS +: CHANNELS] <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/mlp_feature_flattener.sv
// Collects NUM_PIXELS beats of CHANNELS bits into one held flat vector for the MLP.
// Build option FLATTEN_DOUBLE_BUFFER_EN adds a second bank for bubble-free streaming.
module mlp_feature_flattener
  import bnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  mlp_feature_flattener_if.slave  bus
);

  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(NUM_PIXELS - 1);

  logic [COUNT_WIDTH-1:0] count;
  logic                   out_valid_q;
  logic                   frame_err_q;
  logic                   accept;
  logic                   last_slot;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_slot = (count == LAST_IDX);

  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;

`ifdef FLATTEN_DOUBLE_BUFFER_EN

  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  rd_ptr_next;
  logic [1:0]            full;
  logic [1:0]            full_next;
  logic                  complete;
  logic                  consume;
  logic [FLAT_WIDTH-1:0] q0;
  logic [FLAT_WIDTH-1:0] q1;

  assign bus.in_ready = ~(full[0] & full[1]);
  assign complete     = accept && last_slot;
  assign consume      = out_valid_q && bus.out_ready;

  // Completion and consumption may land in the same cycle on different banks
  always_comb begin
    full_next   = full;
    rd_ptr_next = rd_ptr;
    if (complete) begin
      full_next[wr_ptr] = 1'b1;
    end
    if (consume) begin
      full_next[rd_ptr] = 1'b0;
      rd_ptr_next       = ~rd_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      full        <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      full        <= full_next;
      rd_ptr      <= rd_ptr_next;
      out_valid_q <= full_next[rd_ptr_next];
      if (accept) begin
        if (last_slot) begin
          count       <= '0;
          wr_ptr      <= ~wr_ptr;
          frame_err_q <= ~bus.in_last;
        end else if (bus.in_last) begin
          count       <= '0;
          frame_err_q <= 1'b1;
        end else begin
          count <= count + COUNT_WIDTH'(1);
        end
      end
    end
  end

  mlp_flatten_bank u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept && !wr_ptr),
    .wr_idx  (count),
    .wr_data (bus.in_data),
    .q       (q0)
  );

  mlp_flatten_bank u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept && wr_ptr),
    .wr_idx  (count),
    .wr_data (bus.in_data),
    .q       (q1)
  );

  assign bus.out_vec = rd_ptr ? q1 : q0;

`else

  state_t state;

  assign bus.in_ready = (state == FILL);

  // Frame sequencing: fill slots, hold the full vector until the MLP takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      count       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (last_slot) begin
              state       <= FULL;
              out_valid_q <= 1'b1;
              count       <= '0;
              frame_err_q <= ~bus.in_last;
            end else if (bus.in_last) begin
              count       <= '0;
              frame_err_q <= 1'b1;
            end else begin
              count <= count + COUNT_WIDTH'(1);
            end
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            state       <= FILL;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= FILL;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  mlp_flatten_bank u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_idx  (count),
    .wr_data (bus.in_data),
    .q       (bus.out_vec)
  );

`endif

endmodule
